// File: rtl/sound_i2s_tx.sv
// I2S (Philips) stereo transmitter with a one-deep sample holding register.
// BCLK/LRCK are divided down from the system clock. The holding register
// decouples the mixer strobe from the frame boundary. Sticky flags report
// overrun (held sample overwritten) and underrun (nothing held at frame load).
module sound_i2s_tx #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int SLOT_BITS     = 32,
    parameter int BCLK_DIV      = 2
) (
    input  logic                     sCLK_XVXENVS,
    input  logic                     reset_data,
    input  logic                     sample_strobe,
    input  logic [AUD_BIT_DEPTH-1:0] lsound_out,
    input  logic [AUD_BIT_DEPTH-1:0] rsound_out,
    input  logic                     mute,
    input  logic                     clr_status,
    output logic                     AUD_BCLK,
    output logic                     AUD_DACLRCK,
    output logic                     AUD_DACDAT,
    output logic                     overrun,
    output logic                     underrun
);

    localparam int D  = AUD_BIT_DEPTH;
    localparam int FW = 2 * AUD_BIT_DEPTH;
    localparam int KW = $clog2(2 * SLOT_BITS);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(2 * SLOT_BITS - 1);
    localparam logic [KW-1:0] SLOT_K   = KW'(SLOT_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0] div_q,   div_d;
    logic          bclk_q,  bclk_d;
    logic [KW-1:0] k_q,     k_d;
    logic          lrck_q,  lrck_d;
    logic          dat_q,   dat_d;
    logic [FW-1:0] hold_q,  hold_d;
    logic          full_q,  full_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          ovr_q,   ovr_d;
    logic          udr_q,   udr_d;

    logic          wrap, fall, load;
    logic [KW-1:0] k_next, p;
    logic          right;
    logic [D-1:0]  word;
    logic          sel_bit;

    // Divider and bit-position decode; the bit for the upcoming slot position
    // is picked from the frame register (p = 0 is the I2S delay bit).
    always_comb begin
        wrap    = (div_q == DIV_LAST);
        fall    = wrap & bclk_q;
        load    = fall & (k_q == K_LAST);
        k_next  = (k_q == K_LAST) ? '0 : k_q + 1'b1;
        right   = (k_next >= SLOT_K);
        p       = right ? (k_next - SLOT_K) : k_next;
        word    = right ? frame_q[D-1:0] : frame_q[FW-1:D];
        sel_bit = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (p == KW'(D - i)) sel_bit = word[i];
        end
    end

    // Next-state: clock generation, serializer, holding register and flags.
    always_comb begin
        div_d   = wrap ? '0 : div_q + 1'b1;
        bclk_d  = wrap ? ~bclk_q : bclk_q;
        k_d     = k_q;
        lrck_d  = lrck_q;
        dat_d   = dat_q;
        hold_d  = hold_q;
        full_d  = full_q;
        frame_d = frame_q;
        ovr_d   = clr_status ? 1'b0 : ovr_q;
        udr_d   = clr_status ? 1'b0 : udr_q;

        if (fall) begin
            k_d    = k_next;
            lrck_d = right;
            dat_d  = sel_bit;
        end

        // Frame load consumes the held sample; an empty register means underrun.
        if (load) begin
            frame_d = (full_q && !mute) ? hold_q : '0;
            full_d  = 1'b0;
            if (!full_q) udr_d = 1'b1;
        end

        // A strobe always captures; it only overruns if the old sample was not
        // taken by a simultaneous frame load.
        if (sample_strobe) begin
            hold_d = {lsound_out, rsound_out};
            full_d = 1'b1;
            if (full_q && !load) ovr_d = 1'b1;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset_data) begin
            div_q   <= '0;
            bclk_q  <= 1'b0;
            k_q     <= K_LAST;
            lrck_q  <= 1'b0;
            dat_q   <= 1'b0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            frame_q <= '0;
            ovr_q   <= 1'b0;
            udr_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            k_q     <= k_d;
            lrck_q  <= lrck_d;
            dat_q   <= dat_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            frame_q <= frame_d;
            ovr_q   <= ovr_d;
            udr_q   <= udr_d;
        end
    end

    assign AUD_BCLK    = bclk_q;
    assign AUD_DACLRCK = lrck_q;
    assign AUD_DACDAT  = dat_q;
    assign overrun     = ovr_q;
    assign underrun    = udr_q;

endmodule
